// File: rtl/mau_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access size encodings,
// sequencer states and byte-count / byte-enable helpers.
package mau_pkg;

    // Access size encodings (log2 of the byte count)
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Widest supported bus, in bytes
    localparam int unsigned MAX_NB = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } mau_state_e;

    // Number of bytes touched by an access of the given size
    function automatic logic [3:0] nbytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

    // Byte-enable mask for a MAX_NB-byte bus; callers truncate to their width
    function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [2:0] offset);
        logic [15:0] m;
        m = (16'd1 << nbytes(size)) - 16'd1;
        m = m << offset;
        return m[7:0];
    endfunction

endpackage

// File: rtl/mau_load_ext.sv
// Load data alignment: shifts the bus word down to the addressed byte lane,
// keeps the accessed bytes and sign- or zero-extends to the full width.
// Ports:
//   data_i     full-width bus read data
//   size_i     access size (log2 bytes)
//   offset_i   byte offset within the bus word (upper bits zero on narrow buses)
//   unsigned_i 1 = zero-extend, 0 = sign-extend
//   data_o     extended load result
module mau_load_ext
    import mau_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic [DW-1:0] data_i,
    input  logic [1:0]    size_i,
    input  logic [2:0]    offset_i,
    input  logic          unsigned_i,
    output logic [DW-1:0] data_o
);

    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    logic [DW-1:0] shifted;
    logic [DW-1:0] keep_mask;
    logic [DW-1:0] top_mask;
    logic [6:0]    kbits;
    logic          fill;

    // A full-width access shifts ONE out entirely, so the mask wraps to all ones
    always_comb begin
        shifted   = data_i >> {offset_i, 3'b000};
        kbits     = 7'd8 << size_i;
        keep_mask = (ONE << kbits) - ONE;
        top_mask  = keep_mask & ~(keep_mask >> 1);
        fill      = (|(shifted & top_mask)) & ~unsigned_i;
        data_o    = (shifted & keep_mask) | ({DW{fill}} & ~keep_mask);
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns a CPU memory request into a byte-enabled
// bus transaction, stalls while the request/grant/response handshake runs,
// and returns extended load data with a one-cycle completion pulse.
// Optional feature macro: MAU_ALIGN_CHECK_EN (misaligned accesses fault
// instead of being force-aligned).
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (ready only when idle)
//   req_we/size/unsigned/addr/wdata  request payload
//   resp_valid/resp_rdata/resp_exc   completion pulse, load data, exception
//   bus_req/we/addr/be/wdata      held bus request, cleared on bus_gnt
//   bus_gnt, bus_rvalid, bus_rdata   bus grant and read response
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    output logic            resp_valid,
    output logic [DW-1:0]   resp_rdata,
    output logic            resp_exc,
    output logic            bus_req,
    output logic            bus_we,
    output logic [AW-1:0]   bus_addr,
    output logic [DW/8-1:0] bus_be,
    output logic [DW-1:0]   bus_wdata,
    input  logic            bus_gnt,
    input  logic            bus_rvalid,
    input  logic [DW-1:0]   bus_rdata
);

    localparam int unsigned NB = DW / 8;
    localparam int unsigned OW = $clog2(NB);

    mau_state_e    state_q, state_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [OW-1:0] off_q, off_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_exc_q, resp_exc_d;
    logic [DW-1:0] resp_rdata_q, resp_rdata_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [NB-1:0] bus_be_q, bus_be_d;
    logic [DW-1:0] bus_wdata_q, bus_wdata_d;

    logic [3:0]    nb_c;
    logic [OW-1:0] req_off_c;
    logic [OW-1:0] off_mask_c;
    logic [OW-1:0] acc_off_c;
    logic          illegal_c;
    logic          align_fault_c;
    logic [DW-1:0] wdata_rep_c;
    logic [DW-1:0] ext_data_c;

    // Request decode: size legality, offset alignment, store lane replication
    always_comb begin
        nb_c       = nbytes(req_size);
        req_off_c  = req_addr[OW-1:0];
        off_mask_c = OW'(nb_c - 4'd1);
        illegal_c  = 32'(nb_c) > NB;
`ifdef MAU_ALIGN_CHECK_EN
        align_fault_c = |(req_off_c & off_mask_c);
        acc_off_c     = req_off_c;
`else
        align_fault_c = 1'b0;
        acc_off_c     = req_off_c & ~off_mask_c;
`endif
        wdata_rep_c = '0;
        for (int i = 0; i < int'(NB); i++) begin
            int lane;
            lane = i & (int'(nb_c) - 1);
            wdata_rep_c[i*8 +: 8] = req_wdata[lane*8 +: 8];
        end
    end

    mau_load_ext #(
        .DW(DW)
    ) u_load_ext (
        .data_i     (bus_rdata),
        .size_i     (size_q),
        .offset_i   (3'(off_q)),
        .unsigned_i (uns_q),
        .data_o     (ext_data_c)
    );

    // Sequencer next state and registered outputs
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        resp_valid_d = 1'b0;
        resp_exc_d   = resp_exc_q;
        resp_rdata_d = resp_rdata_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d         = req_we;
                    size_d       = req_size;
                    uns_d        = req_unsigned;
                    off_d        = acc_off_c;
                    resp_rdata_d = '0;
                    resp_exc_d   = 1'b0;
                    if (illegal_c || align_fault_c) begin
                        state_d      = ST_DONE;
                        resp_valid_d = 1'b1;
                        resp_exc_d   = 1'b1;
                        bus_we_d     = 1'b0;
                        bus_addr_d   = '0;
                        bus_be_d     = '0;
                        bus_wdata_d  = '0;
                    end else begin
                        state_d     = ST_REQ;
                        bus_req_d   = 1'b1;
                        bus_we_d    = req_we;
                        bus_addr_d  = {req_addr[AW-1:OW], {OW{1'b0}}};
                        bus_be_d    = req_we ? NB'(be_mask(req_size, 3'(acc_off_c))) : '0;
                        bus_wdata_d = req_we ? wdata_rep_c : '0;
                    end
                end
            end
            ST_REQ: begin
                if (bus_gnt) begin
                    bus_req_d = 1'b0;
                    if (we_q) begin
                        state_d      = ST_DONE;
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (bus_rvalid) begin
                    state_d      = ST_DONE;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = ext_data_c;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            size_q       <= SZ_B;
            uns_q        <= 1'b0;
            off_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_exc_q   <= 1'b0;
            resp_rdata_q <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= '0;
            bus_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            resp_valid_q <= resp_valid_d;
            resp_exc_q   <= resp_exc_d;
            resp_rdata_q <= resp_rdata_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_exc   = resp_exc_q;
    assign resp_rdata = resp_rdata_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;

endmodule
